ec_fe_addsub_server: RTL
========================

// Module: ec_fe_addsub_server
// PURPOSE
// - Responder end of the FE add/sub request interface that the EC point
//   units drive (o_add_if/i_add_if, o_sub_if/i_sub_if).
// - Accepts {b,a} operand pairs with a tag and returns (a+b) mod P or
//   (a-b) mod P with the tag echoed.
// - Fully pipelined, 1 result/cycle, honours backpressure.
// - Instantiated once per operation, beside the point add/dbl and
//   fe2 arithmetic blocks.
// PARAMETERS
// - DAT_BITS  381                  operand width in bits; FE_TYPE width
// - CTL_BITS  8                    width of the ctl tag, passed through unchanged
// - P         bls12_381_pkg::P     modulus, DAT_BITS wide, P > 1
// - SUB       0                    0 = modular add; 1 = modular subtract
// PORTS
// - i_clk       in   1                  clock
// - i_rst       in   1                  asynchronous, active-high reset
// - i_req_if    sink  if_axi_stream (DAT_BITS=2*DAT_BITS, CTL_BITS)
//   - dat = {b, a}: a = dat[DAT_BITS-1:0], b = upper half
//   - also val, rdy, sop, eop, ctl
// - o_res_if    source if_axi_stream (DAT_BITS, CTL_BITS)
//   - dat = result; val, rdy, sop, eop, ctl, err
// BEHAVIOUR
// - Reset (async, active-high):
//   - all stage valids cleared; o_res_if.val=0
//   - o_res_if.dat/ctl/sop/eop/err = 0; i_req_if.rdy=0 while i_rst=1
//   - in-flight requests are discarded; no partial result ever appears.
// - Two register stages, S1 -> S2; S2 drives o_res_if directly.
// - S1, on accept (i_req_if.val & i_req_if.rdy):
//   - SUB=0: t = a + b, DAT_BITS+1 bits.
//   - SUB=1: t = a - b, DAT_BITS+1 bits, 2's complement, MSB = borrow.
//   - Also registers ctl/sop/eop and range flag r = (a>=P)|(b>=P).
// - S2:
//   - SUB=0: res = (t >= P) ? t - P : t.
//   - SUB=1: res = borrow ? t + P (truncated to DAT_BITS) : t.
//   - err = r; the result is still computed and returned, not dropped.
// - Latency: 2 cycles from accept to o_res_if.val with no backpressure.
//   Throughput 1/cycle.
// - Handshake:
//   - S2 loads when it is empty or o_res_if.rdy=1.
//   - S1 loads when it is empty or S2 loads.
//   - i_req_if.rdy = ~S1.val | S2 loads (registered-path-free).
// - o_res_if.val/dat/ctl held stable while val=1 & rdy=0 (AXI rule).
// - Simultaneous accept and output in one cycle: both occur, no bubble.
// - Order preserved strictly; ctl/sop/eop returned bit-exact; mod field
//   ignored on input, driven 0 on output.
// - Full: both stages valid and rdy=0, so i_req_if.rdy=0.
//   The first cycle o_res_if.rdy rises, one result drains and one request
//   is accepted.
// - Empty: o_res_if.val=0; input accepted immediately.
// - Boundaries:
//   - a+b == P gives 0.
//   - a-b == 0 gives 0.
//   - a=0,b=P-1 (SUB) gives 1.
//   - (P-1)+(P-1) gives P-2 (max t, no overflow of DAT_BITS+1).
// STRUCTURE
// - P and FE_TYPE come from the shared curve package (bls12_381_pkg).
//   No new typedefs are added.
// - Widths are derived from DAT_BITS/CTL_BITS parameters only.
// - One natural sub-module: ec_fe_addsub_stage.
//   - A valid/ready pipeline register carrying {dat, ctl, sop, eop, flag}.
//   - Instantiated twice (S1, S2); arithmetic stays in the top module.
// - No multi-cycle FSM: state is the two stage-valid bits.
//   - States: EMPTY, ONE (S1 or S2), FULL.
// TESTING
// - Test setup:
//   - Small config DAT_BITS=4, P=13, plus one run with DAT_BITS=381,
//     P=BLS12-381.
//   - Scoreboard compares against a Python-style big-int reference model.
// - Scenarios:
//   - Add, a=5,b=7 -> 12; a=6,b=7 -> 0; a=12,b=12 -> 11.
//     Each has latency exactly 2, ctl echoed (0x3A in, 0x3A out).
//   - Sub, a=7,b=5 -> 2; a=5,b=5 -> 0; a=0,b=12 -> 1; a=3,b=9 -> 7.
//     sop/eop pass through.
//   - Backpressure:
//     - Stream 16 random pairs, o_res_if.rdy toggling 50%.
//     - All 16 results arrive in order; no loss or duplication.
//     - dat is stable while stalled; i_req_if.rdy=0 only when both stages
//       are full.
//   - Out-of-range input: a=14,b=1 (P=13) -> err=1 on that beat only,
//     next beat err=0.
//   - Reset mid-flight:
//     - 2 requests accepted, rdy held 0, assert i_rst asynchronously.
//     - o_res_if.val drops at once; after release, no stale result.
//     - The next request returns correct data.
//   - BLS12-381 streaming:
//     - 1000 back-to-back random pairs with rdy=1.
//     - 1 result/cycle after 2-cycle fill, all match the model.

Source files
------------

// File: rtl/ec_fe_addsub_server_pkg.sv
// Shared constants for the FE add/sub responder.
// BLS12_381_P is the base-field modulus used as the default P of the server.
package ec_fe_addsub_server_pkg;

  localparam int unsigned BLS_DAT_BITS = 381;
  localparam int unsigned BLS_CTL_BITS = 8;

  localparam logic [BLS_DAT_BITS-1:0] BLS12_381_P =
    381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;

endpackage

// File: rtl/ec_fe_addsub_stage.sv
// One valid/ready pipeline register.
// Ports:
//   i_clk, i_rst  clock, asynchronous active-high reset
//   load_i        stage takes val_i/dat_i this cycle
//   val_i, dat_i  incoming beat (dat captured only with a valid beat)
//   val_o, dat_o  registered stage contents
module ec_fe_addsub_stage
  import ec_fe_addsub_server_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         load_i,
  input  logic         val_i,
  input  logic [W-1:0] dat_i,
  output logic         val_o,
  output logic [W-1:0] dat_o
);

  logic         val_q;
  logic [W-1:0] dat_q;

  // Payload only moves with a valid beat so dat stays stable across bubbles.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      val_q <= 1'b0;
      dat_q <= '0;
    end else if (load_i) begin
      val_q <= val_i;
      if (val_i) begin
        dat_q <= dat_i;
      end
    end
  end

  assign val_o = val_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/ec_fe_addsub_server.sv
// Pipelined modular add/sub responder: returns (a+b) mod P (SUB=0) or
// (a-b) mod P (SUB=1) two cycles after accept, one result per cycle.
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   req_val_i/req_rdy_o   request handshake; req_dat_i = {b, a}
//   req_ctl_i/sop/eop     tag and framing, echoed unchanged
//   res_val_o/res_rdy_i   result handshake; res_dat_o = result
//   res_ctl_o/sop/eop     echoed tag and framing
//   res_err_o             an operand was >= P (result still returned)
// Occupancy is the two stage-valid bits: EMPTY, ONE (S1 or S2), FULL.
module ec_fe_addsub_server
  import ec_fe_addsub_server_pkg::*;
#(
  parameter int unsigned          DAT_BITS = BLS_DAT_BITS,
  parameter int unsigned          CTL_BITS = BLS_CTL_BITS,
  parameter logic [DAT_BITS-1:0]  P        = BLS12_381_P,
  parameter bit                   SUB      = 1'b0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    req_val_i,
  input  logic [2*DAT_BITS-1:0]   req_dat_i,
  input  logic [CTL_BITS-1:0]     req_ctl_i,
  input  logic                    req_sop_i,
  input  logic                    req_eop_i,
  output logic                    req_rdy_o,
  output logic                    res_val_o,
  output logic [DAT_BITS-1:0]     res_dat_o,
  output logic [CTL_BITS-1:0]     res_ctl_o,
  output logic                    res_sop_o,
  output logic                    res_eop_o,
  output logic                    res_err_o,
  input  logic                    res_rdy_i
);

  localparam int unsigned T_BITS  = DAT_BITS + 1;
  localparam int unsigned S1_BITS = T_BITS + CTL_BITS + 3;
  localparam int unsigned S2_BITS = DAT_BITS + CTL_BITS + 3;

  logic [DAT_BITS-1:0] a, b;
  logic [T_BITS-1:0]   p_ext;
  logic [T_BITS-1:0]   t_d, t_q;
  logic                r_d, r_q;
  logic [CTL_BITS-1:0] ctl_q;
  logic                sop_q, eop_q;
  logic [DAT_BITS-1:0] res_d;
  logic                s1_val, s2_val, s1_load, s2_load;
  logic [S1_BITS-1:0]  s1_q;
  logic [S2_BITS-1:0]  s2_q;

  assign a     = req_dat_i[DAT_BITS-1:0];
  assign b     = req_dat_i[2*DAT_BITS-1:DAT_BITS];
  assign p_ext = {1'b0, P};

  // S1 arithmetic: widened sum, or two's-complement difference with MSB = borrow.
  always_comb begin
    t_d = SUB ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    r_d = (a >= P) | (b >= P);
  end

  // Backpressure ripples from the output; ready never depends on a registered path beyond stage valids.
  assign s2_load   = ~s2_val | res_rdy_i;
  assign s1_load   = ~s1_val | s2_load;
  assign req_rdy_o = ~i_rst & s1_load;

  ec_fe_addsub_stage #(.W(S1_BITS)) u_s1 (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .load_i (s1_load),
    .val_i  (req_val_i),
    .dat_i  ({t_d, req_ctl_i, req_sop_i, req_eop_i, r_d}),
    .val_o  (s1_val),
    .dat_o  (s1_q)
  );

  assign {t_q, ctl_q, sop_q, eop_q, r_q} = s1_q;

  // S2 single conditional correction back into [0, P).
  always_comb begin
    res_d = DAT_BITS'(t_q);
    if (SUB) begin
      if (t_q[DAT_BITS]) begin
        res_d = DAT_BITS'(t_q + p_ext);
      end
    end else if (t_q >= p_ext) begin
      res_d = DAT_BITS'(t_q - p_ext);
    end
  end

  ec_fe_addsub_stage #(.W(S2_BITS)) u_s2 (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .load_i (s2_load),
    .val_i  (s1_val),
    .dat_i  ({res_d, ctl_q, sop_q, eop_q, r_q}),
    .val_o  (s2_val),
    .dat_o  (s2_q)
  );

  assign res_val_o = s2_val;
  assign {res_dat_o, res_ctl_o, res_sop_o, res_eop_o, res_err_o} = s2_q;

endmodule
